// File: rtl/hurricane_mode_controller.sv
// Exhaust hood mode sequencer: key/menu edge decode, one-shot hurricane countdown, return-to-standby countdown.
// Latency: an input edge sampled at a clk edge is reflected on the outputs right after that edge; no backpressure (level inputs only).
module hurricane_mode_controller #(
    parameter int MODE_WIDTH     = 3,
    parameter int MAX_WIDTH      = 32,
    parameter int COUNTER_1SEC   = 100_000_000 - 1,
    parameter int HURRICANE_TIME = 60,
    parameter int RETURN_TIME    = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  power_on,
    input  logic                  key_first,
    input  logic                  key_second,
    input  logic                  key_third,
    input  logic                  menu_signal,
    output logic [MODE_WIDTH-1:0] current_mode,
    output logic [MAX_WIDTH-1:0]  remaining_time,
    output logic                  third_used,
    output logic                  exit_pulse
);

    typedef enum logic [MODE_WIDTH-1:0] {
        OFF          = MODE_WIDTH'(0),
        STANDBY      = MODE_WIDTH'(1),
        FIRST        = MODE_WIDTH'(2),
        SECOND       = MODE_WIDTH'(3),
        THIRD        = MODE_WIDTH'(4),
        THIRD_RETURN = MODE_WIDTH'(5)
    } mode_t;

    mode_t                state;
    logic [MAX_WIDTH-1:0] sec_cnt;
    logic                 key_first_q;
    logic                 key_second_q;
    logic                 key_third_q;
    logic                 menu_q;

    logic first_rise;
    logic second_rise;
    logic third_rise;
    logic menu_rise;
    logic tick;

    assign first_rise  = key_first   & ~key_first_q;
    assign second_rise = key_second  & ~key_second_q;
    assign third_rise  = key_third   & ~key_third_q;
    assign menu_rise   = menu_signal & ~menu_q;
    assign tick        = (sec_cnt == MAX_WIDTH'(COUNTER_1SEC));

    assign current_mode = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= OFF;
            remaining_time <= '0;
            sec_cnt        <= '0;
            third_used     <= 1'b0;
            exit_pulse     <= 1'b0;
            key_first_q    <= 1'b0;
            key_second_q   <= 1'b0;
            key_third_q    <= 1'b0;
            menu_q         <= 1'b0;
        end else begin
            key_first_q  <= key_first;
            key_second_q <= key_second;
            key_third_q  <= key_third;
            menu_q       <= menu_signal;
            exit_pulse   <= 1'b0;

            if (!power_on) begin
                state          <= OFF;
                remaining_time <= '0;
                sec_cnt        <= '0;
                third_used     <= 1'b0;
            end else begin
                case (state)
                    OFF: begin
                        state <= STANDBY;
                    end
                    STANDBY: begin
                        if (first_rise) begin
                            state <= FIRST;
                        end else if (second_rise) begin
                            state <= SECOND;
                        end else if (third_rise && !third_used) begin
                            state          <= THIRD;
                            remaining_time <= MAX_WIDTH'(HURRICANE_TIME);
                            sec_cnt        <= '0;
                            third_used     <= 1'b1;
                        end
                    end
                    FIRST, SECOND: begin
                        if (menu_rise) begin
                            state <= STANDBY;
                        end else if (first_rise) begin
                            state <= FIRST;
                        end else if (second_rise) begin
                            state <= SECOND;
                        end
                    end
                    THIRD, THIRD_RETURN: begin
                        // Expiry outranks a coincident menu edge, which is then simply dropped.
                        if (tick && remaining_time <= MAX_WIDTH'(1)) begin
                            state          <= (state == THIRD) ? SECOND : STANDBY;
                            remaining_time <= '0;
                            sec_cnt        <= '0;
                            exit_pulse     <= 1'b1;
                        end else if (menu_rise && state == THIRD) begin
                            state          <= THIRD_RETURN;
                            remaining_time <= MAX_WIDTH'(RETURN_TIME);
                            sec_cnt        <= '0;
                        end else if (tick) begin
                            sec_cnt        <= '0;
                            remaining_time <= remaining_time - MAX_WIDTH'(1);
                        end else begin
                            sec_cnt <= sec_cnt + MAX_WIDTH'(1);
                        end
                    end
                    default: begin
                        state          <= STANDBY;
                        remaining_time <= '0;
                        sec_cnt        <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hurricane_mode_controller.sv
// Vector-table bench for hurricane_mode_controller with a small second length (4 cycles).
module tb_hurricane_mode_controller;

    localparam int CPS = 4;  // cycles per second with COUNTER_1SEC=3
    localparam int HT  = 5;
    localparam int RT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        power_on;
    logic        key_first;
    logic        key_second;
    logic        key_third;
    logic        menu_signal;
    logic [2:0]  current_mode;
    logic [31:0] remaining_time;
    logic        third_used;
    logic        exit_pulse;

    always #5 clk = ~clk;

    hurricane_mode_controller #(
        .MODE_WIDTH(3),
        .MAX_WIDTH(32),
        .COUNTER_1SEC(CPS - 1),
        .HURRICANE_TIME(HT),
        .RETURN_TIME(RT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .power_on(power_on),
        .key_first(key_first),
        .key_second(key_second),
        .key_third(key_third),
        .menu_signal(menu_signal),
        .current_mode(current_mode),
        .remaining_time(remaining_time),
        .third_used(third_used),
        .exit_pulse(exit_pulse)
    );

    typedef struct {
        logic        rst, pwr, k1, k2, k3, menu;
        logic [2:0]  mode;
        logic [31:0] rt;
        logic        tu, ep;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   mon_idx = 0;
    bit   done = 0;

    function automatic void add(bit r, bit p, bit a, bit b, bit c, bit m,
                                int mode, int rt, bit tu, bit ep);
        vec_t v;
        v.rst = r; v.pwr = p; v.k1 = a; v.k2 = b; v.k3 = c; v.menu = m;
        v.mode = 3'(mode); v.rt = 32'(rt); v.tu = tu; v.ep = ep;
        vecs.push_back(v);
    endfunction

    // Idle cycles i0..i1 after countdown entry; remaining time drops once per full second.
    function automatic void add_count(int mode, int start, int i0, int i1);
        for (int i = i0; i <= i1; i++) add(0, 1, 0, 0, 0, 0, mode, start - i / CPS, 1, 0);
    endfunction

    function automatic void power_cycle();
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    endfunction

    function automatic void chk(string nm, int idx, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL vec%0d %s: got %0d, want %0d", idx, nm, got, want);
        end
    endfunction

    always @(posedge clk) begin
        vec_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("current_mode",   mon_idx, 32'(current_mode),   32'(e.mode));
            chk("remaining_time", mon_idx, remaining_time,      e.rt);
            chk("third_used",     mon_idx, 32'(third_used),     32'(e.tu));
            chk("exit_pulse",     mon_idx, 32'(exit_pulse),     32'(e.ep));
            mon_idx++;
        end
    end

    initial begin
        rst = 1; power_on = 0; key_first = 0; key_second = 0; key_third = 0; menu_signal = 0;

        // reset and power-up
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        // simultaneous first+second, menu back, held first acts once
        add(0, 1, 1, 1, 0, 0, 2, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 1, 0, 0, 0, 2, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        // hurricane key ignored outside standby
        add(0, 1, 0, 1, 0, 0, 3, 0, 0, 0);
        add(0, 1, 0, 1, 1, 0, 3, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        // uninterrupted hurricane expiry
        add(0, 1, 0, 0, 1, 0, 4, HT, 1, 0);
        add_count(4, HT, 1, HT * CPS - 1);
        add(0, 1, 0, 0, 0, 0, 3, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 3, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        // power cycle re-arms; menu return from rt=3 with ignored keys/menu
        power_cycle();
        add(0, 1, 0, 0, 1, 0, 4, HT, 1, 0);
        add_count(4, HT, 1, 2 * CPS);
        add(0, 1, 0, 0, 0, 1, 5, RT, 1, 0);
        for (int j = 1; j < RT * CPS; j++)
            add(0, 1, j == 5, 0, j == 7, j == 2, 5, RT - j / CPS, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        // menu edge on the expiry cycle: expiry wins
        power_cycle();
        add(0, 1, 0, 0, 1, 0, 4, HT, 1, 0);
        add_count(4, HT, 1, HT * CPS - 1);
        add(0, 1, 0, 0, 0, 1, 3, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 3, 0, 1, 0);
        // power loss at rt=2 in hurricane
        power_cycle();
        add(0, 1, 0, 0, 1, 0, 4, HT, 1, 0);
        add_count(4, HT, 1, 3 * CPS);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset at rt=2 in return countdown
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 4, HT, 1, 0);
        add(0, 1, 0, 0, 0, 1, 5, RT, 1, 0);
        for (int j = 1; j <= CPS; j++) add(0, 1, 0, 0, 0, 0, 5, RT - j / CPS, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; power_on = vecs[i].pwr;
            key_first = vecs[i].k1; key_second = vecs[i].k2;
            key_third = vecs[i].k3; menu_signal = vecs[i].menu;
            exp_q.push_back(vecs[i]);
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 || mon_idx != vecs.size()) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        done = 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        if (!done) begin
            errors++;
            $display("FAIL timeout: got no completion, want completion by 50000");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

endmodule

// File: doc/hurricane_mode_controller.md
Name: hurricane_mode_controller

Overview:
- Mode-sequencing controller for the exhaust hood. It decodes power and key inputs into the current mode, drives `current_mode` for the per-mode event modules, and owns the hurricane (third) mode countdown and exit sequencing.
- Enforces once-per-power-on hurricane use.
- On countdown expiry it automatically falls back to second mode.
- A menu press during hurricane starts a fixed return countdown that ends in standby.

Parameters:
- MODE_WIDTH, 3, width of the mode encoding.
- MAX_WIDTH, 32, width of the time and counter registers.
- COUNTER_1SEC, 100_000_000-1, terminal count of the cycle counter; one second = COUNTER_1SEC+1 cycles.
- HURRICANE_TIME, 60, seconds of hurricane operation.
- RETURN_TIME, 60, seconds from a menu press in hurricane to standby.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- power_on  in  1  level; 1 = hood powered.
- key_first  in  1  level, debounced; first-mode key.
- key_second  in  1  level, debounced; second-mode key.
- key_third  in  1  level, debounced; hurricane key.
- menu_signal  in  1  level, debounced; menu/return key.
- current_mode  out  MODE_WIDTH  registered mode code.
- remaining_time  out  MAX_WIDTH  registered seconds left in the active countdown; 0 otherwise.
- third_used  out  1  registered; hurricane already used this power cycle.
- exit_pulse  out  1  one-cycle pulse when a countdown expires.

Behaviour:
- Mode codes:
  - OFF=0, STANDBY=1, FIRST=2, SECOND=3, THIRD=4, THIRD_RETURN=5.
  - Codes 6 and 7 are illegal and go to STANDBY on the next cycle.
- Reset (rst=1 at a clk edge), all registers cleared:
  - current_mode=OFF, remaining_time=0, third_used=0, exit_pulse=0.
  - Cycle counter = 0; key/menu history registers = 0.
- Edge detection: each key and menu input is registered once. A rising edge is input=1 while the history register=0. Held keys act once.
- Latency: an input edge sampled at edge k appears on current_mode and remaining_time after edge k; there is no extra pipeline stage.
- Priority per cycle (highest first): rst > power_on=0 > countdown expiry > menu edge > key edges. Among keys: first > second > third.
- Any state with power_on=0:
  - current_mode goes to OFF; third_used, remaining_time, the cycle counter and exit_pulse are cleared.
  - No exit_pulse is generated.
- OFF:
  - power_on=1 goes to STANDBY.
- STANDBY:
  - key_first edge goes to FIRST; key_second edge goes to SECOND.
  - key_third edge goes to THIRD only if third_used=0; otherwise it is ignored.
  - menu edge has no effect.
- FIRST / SECOND:
  - key_first and key_second edges switch between them.
  - menu edge goes to STANDBY.
  - key_third edge is ignored; hurricane is entered only from STANDBY.
- Entry to THIRD:
  - remaining_time=HURRICANE_TIME, cycle counter=0, third_used=1.
  - third_used stays set until power off or rst.
- THIRD:
  - The cycle counter increments every cycle. When counter==COUNTER_1SEC it wraps to 0 and the second ticks.
  - Tick with remaining_time>1: remaining_time decrements.
  - Tick with remaining_time==1 (expiry): go to SECOND, remaining_time=0, counter=0, exit_pulse=1 for exactly one cycle.
  - Menu edge: go to THIRD_RETURN, remaining_time reloaded to RETURN_TIME, counter=0.
  - Menu edge on the same cycle as expiry: expiry wins (SECOND); the menu edge is consumed and dropped.
  - Key edges are ignored.
- THIRD_RETURN:
  - Same tick rule as THIRD.
  - Expiry goes to STANDBY with exit_pulse=1 for one cycle.
  - Further menu edges and key edges are ignored; the countdown does not reload.
- Residency: THIRD lasts exactly HURRICANE_TIME*(COUNTER_1SEC+1) cycles when uninterrupted.
- remaining_time is 0 in every state other than THIRD and THIRD_RETURN.
- Arithmetic: all counters are MAX_WIDTH unsigned, with no wrap below 0. HURRICANE_TIME>=1 and RETURN_TIME>=1 are required.
- rst mid-countdown: next cycle everything is at reset values; no exit_pulse.

Test Plan (all scenarios use COUNTER_1SEC=3, HURRICANE_TIME=5, RETURN_TIME=3):
- Reset / power-up: rst=1 then 0, power_on=1 → current_mode OFF then STANDBY one cycle later; remaining_time=0, third_used=0, exit_pulse=0.
- Hurricane expiry: STANDBY, key_third pulse → current_mode=4, remaining_time=5, third_used=1. remaining_time reaches 4,3,2,1 at cycles 4,8,12,16 after entry. At cycle 20: mode=3, remaining_time=0, exit_pulse=1 for one cycle.
- Menu return: in THIRD with remaining_time=3, menu edge → mode=5, remaining_time=3. After 12 cycles: mode=1, exit_pulse=1. A key_third edge in the subsequent STANDBY is ignored (mode stays 1).
- Single use: after one hurricane, power_on 1→0→1 → third_used=0. key_third edge then gives mode=4.
- Simultaneous events:
  - Menu edge on the expiry cycle of THIRD → mode=3, not 5.
  - key_first and key_second edges together in STANDBY → mode=2.
  - Held key_first for 10 cycles then menu → FIRST, then STANDBY, with no re-entry.
- Power loss / reset mid-countdown:
  - power_on=0 at remaining_time=2 in THIRD → mode=0, remaining_time=0, no exit_pulse.
  - rst=1 at remaining_time=2 in THIRD_RETURN → mode=0, remaining_time=0, third_used=0, no exit_pulse.
